// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch tracking queue with lookup-table update and mispredict redirect
module branch_resolve_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  push_taken,
    input  logic [ADDR_WIDTH-1:0] push_target,
    output logic                  full,
    output logic                  empty,
    input  logic                  resolve,
    input  logic [ADDR_WIDTH-1:0] resolve_pc,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    output logic                  blt_write,
    output logic [ADDR_WIDTH-1:0] blt_write_key,
    output logic [ADDR_WIDTH-1:0] blt_write_val,
    output logic                  blt_hit,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  order_error,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
    logic                  taken_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0] target_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count;

    logic                  head_taken;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  resolve_ok;
    logic                  resolve_bad;
    logic                  mispredict_now;
    logic                  push_ok;
    logic                  write_now;
    logic [ADDR_WIDTH-1:0] redirect_next;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    assign head_pc     = pc_mem[head];
    assign head_taken  = taken_mem[head];
    assign head_target = target_mem[head];

    always_comb begin
        resolve_ok     = 1'b0;
        resolve_bad    = 1'b0;
        mispredict_now = 1'b0;
        write_now      = 1'b0;
        push_ok        = 1'b0;
        redirect_next  = resolve_pc + ADDR_WIDTH'(1);
        if (resolve) begin
            resolve_ok  = !empty && (head_pc == resolve_pc);
            resolve_bad = !resolve_ok;
        end
        if (resolve_ok) begin
            write_now      = resolve_taken | head_taken;
            mispredict_now = (head_taken != resolve_taken) ||
                             (head_taken && resolve_taken && (head_target != resolve_target));
        end
        if (resolve_taken) begin
            redirect_next = resolve_target;
        end
        // a push alongside a mispredicting resolve is already on the wrong path
        push_ok = push && (!full || resolve_ok) && !mispredict_now;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[tail]     <= push_pc;
            taken_mem[tail]  <= push_taken;
            target_mem[tail] <= push_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict_now) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (resolve_ok) begin
                head <= head + 1'b1;
            end
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            case ({push_ok, resolve_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blt_write        <= 1'b0;
            blt_write_key    <= '0;
            blt_write_val    <= '0;
            blt_hit          <= 1'b0;
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            order_error      <= 1'b0;
            mispredict_count <= '0;
        end else begin
            blt_write   <= write_now;
            mispredict  <= mispredict_now;
            order_error <= resolve_bad;
            if (resolve_ok) begin
                blt_write_key <= resolve_pc;
                blt_write_val <= resolve_target;
                blt_hit       <= resolve_taken;
            end
            if (mispredict_now) begin
                redirect_pc <= redirect_next;
                if (mispredict_count != '1) begin
                    mispredict_count <= mispredict_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [15:0] push_pc;
    logic        push_taken;
    logic [15:0] push_target;
    logic        full;
    logic        empty;
    logic        resolve;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        blt_write;
    logic [15:0] blt_write_key;
    logic [15:0] blt_write_val;
    logic        blt_hit;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic        order_error;
    logic [3:0]  mispredict_count;

    branch_resolve_queue #(
        .ADDR_WIDTH(16),
        .DEPTH(8),
        .DEPTH_LOG2(3),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_pc(push_pc),
        .push_taken(push_taken),
        .push_target(push_target),
        .full(full),
        .empty(empty),
        .resolve(resolve),
        .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .blt_write(blt_write),
        .blt_write_key(blt_write_key),
        .blt_write_val(blt_write_val),
        .blt_hit(blt_hit),
        .mispredict(mispredict),
        .redirect_pc(redirect_pc),
        .order_error(order_error),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        tk;
        logic [15:0] tg;
    } ent_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] key;
        logic [15:0] val;
        logic        hit;
        logic        mis;
        logic [15:0] redir;
        logic        oerr;
        logic [3:0]  cnt;
        logic        emp;
        logic        ful;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;
    logic [3:0] model_cnt = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    task automatic cycle(input logic p, input logic [15:0] ppc, input logic ptk, input logic [15:0] ptg,
                         input logic r, input logic [15:0] rpc, input logic rtk, input logic [15:0] rtg);
        exp_t e;
        ent_t h;
        ent_t n;
        logic valid;
        logic fullb;
        push = p; push_pc = ppc; push_taken = ptk; push_target = ptg;
        resolve = r; resolve_pc = rpc; resolve_taken = rtk; resolve_target = rtg;
        e = '0;
        valid = r && (mq.size() != 0) && (mq[0].pc == rpc);
        fullb = (mq.size() == 8);
        if (valid) begin
            h = mq[0];
            e.wr    = rtk | h.tk;
            e.key   = rpc;
            e.val   = rtg;
            e.hit   = rtk;
            e.mis   = (h.tk != rtk) || (h.tk && rtk && (h.tg != rtg));
            e.redir = rtk ? rtg : rpc + 16'd1;
        end
        e.oerr = r && !valid;
        if (e.mis) begin
            mq.delete();
            if (model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        end else begin
            if (valid) void'(mq.pop_front());
            if (p && (!fullb || valid)) begin
                n.pc = ppc; n.tk = ptk; n.tg = ptg;
                mq.push_back(n);
            end
        end
        e.cnt = model_cnt;
        e.emp = (mq.size() == 0);
        e.ful = (mq.size() == 8);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check("blt_write", 32'(blt_write), 32'(e.wr));
        check("mispredict", 32'(mispredict), 32'(e.mis));
        check("order_error", 32'(order_error), 32'(e.oerr));
        check("mispredict_count", 32'(mispredict_count), 32'(e.cnt));
        check("empty", 32'(empty), 32'(e.emp));
        check("full", 32'(full), 32'(e.ful));
        if (e.wr) begin
            check("blt_write_key", 32'(blt_write_key), 32'(e.key));
            check("blt_write_val", 32'(blt_write_val), 32'(e.val));
            check("blt_hit", 32'(blt_hit), 32'(e.hit));
        end
        if (e.mis) check("redirect_pc", 32'(redirect_pc), 32'(e.redir));
        push = 1'b0;
        resolve = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
        cycle(1'b1, pc, tk, tg, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic do_resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
        cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, pc, tk, tg);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_blt_write"}, 32'(blt_write), 32'd0);
        check({tag, "_key"}, 32'(blt_write_key), 32'd0);
        check({tag, "_val"}, 32'(blt_write_val), 32'd0);
        check({tag, "_hit"}, 32'(blt_hit), 32'd0);
        check({tag, "_mispredict"}, 32'(mispredict), 32'd0);
        check({tag, "_redirect"}, 32'(redirect_pc), 32'd0);
        check({tag, "_order_error"}, 32'(order_error), 32'd0);
        check({tag, "_count"}, 32'(mispredict_count), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        push = 1'b0; push_pc = '0; push_taken = 1'b0; push_target = '0;
        resolve = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;
        #12;
        check_all_zero("reset");
        #5;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // correctly predicted taken branch
        do_push(16'h0010, 1'b1, 16'h0040);
        do_resolve(16'h0010, 1'b1, 16'h0040);

        // predicted not-taken, actually taken
        do_push(16'h0020, 1'b0, 16'h0000);
        do_resolve(16'h0020, 1'b1, 16'h0080);

        // predicted taken, actually not-taken; wrong-path push dropped
        do_push(16'h0030, 1'b1, 16'h0050);
        cycle(1'b1, 16'h0031, 1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h0000);

        // fill, overflow, push+pop while full, drain with wrap
        for (int i = 0; i < 8; i++) do_push(16'h0100 + 16'(i), 1'(i % 2), 16'h0200 + 16'(i));
        do_push(16'h01FF, 1'b1, 16'h0300);
        cycle(1'b1, 16'h0108, 1'b1, 16'h0208, 1'b1, 16'h0100, 1'b0, 16'h0200);
        for (int i = 0; i < 8; i++) begin
            ent_t h;
            h = mq.size() != 0 ? mq[0] : '0;
            do_resolve(h.pc, h.tk, h.tg);
        end

        // order errors: empty queue and PC mismatch
        do_resolve(16'h0010, 1'b1, 16'h0040);
        do_push(16'h0010, 1'b1, 16'h0040);
        do_resolve(16'h0099, 1'b1, 16'h0040);
        do_resolve(16'h0010, 1'b1, 16'h0040);

        // drive the statistics counter into saturation
        for (int i = 0; i < 14; i++) begin
            do_push(16'h0040 + 16'(i), 1'b0, 16'h0000);
            do_resolve(16'h0040 + 16'(i), 1'b1, 16'h0090);
        end
        check("count_saturated", 32'(mispredict_count), 32'hF);

        // asynchronous reset with entries in flight
        do_push(16'h0200, 1'b1, 16'h0210);
        do_push(16'h0201, 1'b1, 16'h0211);
        do_push(16'h0202, 1'b0, 16'h0000);
        do_resolve(16'h0200, 1'b1, 16'h0210);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        mq.delete();
        model_cnt = 4'd0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_push(16'h0300, 1'b1, 16'h0310);
        do_resolve(16'h0300, 1'b1, 16'h0310);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every branch that fetch issues with a prediction from the branch lookup table, in program order.
- When execute resolves a branch, compares the actual outcome with the recorded prediction.
- Drives the lookup table's update port (write, write_key, write_val, hit), plus a mispredict/redirect pulse that flushes the front end.
- Sits between fetch (push side), execute (resolve side) and the branch lookup table (write side).

Parameters:
- ADDR_WIDTH, 16, width of PCs and targets.
- DEPTH, 8, number of in-flight branch entries.
- DEPTH_LOG2, 3, log2(DEPTH); DEPTH must be a power of two.
- CNT_WIDTH, 16, width of the mispredict statistics counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  fetch issued a branch this cycle.
- push_pc  in  ADDR_WIDTH  branch PC.
- push_taken  in  1  predicted taken (lookup read_valid).
- push_target  in  ADDR_WIDTH  predicted target (lookup read_val).
- full  out  1  queue holds DEPTH entries (combinational from count).
- empty  out  1  queue holds 0 entries.
- resolve  in  1  execute resolved the oldest branch.
- resolve_pc  in  ADDR_WIDTH  PC of resolved branch.
- resolve_taken  in  1  actual direction.
- resolve_target  in  ADDR_WIDTH  actual target.
- blt_write  out  1  registered, to lookup table write.
- blt_write_key  out  ADDR_WIDTH  registered, to write_key.
- blt_write_val  out  ADDR_WIDTH  registered, to write_val.
- blt_hit  out  1  registered, to hit.
- mispredict  out  1  registered one-cycle pulse.
- redirect_pc  out  ADDR_WIDTH  registered, valid when mispredict=1.
- order_error  out  1  registered one-cycle pulse.
- mispredict_count  out  CNT_WIDTH  saturating statistics counter.

Behaviour:
- Reset (reset=0, asynchronous):
  - Head, tail and count are 0.
  - All registered outputs are 0; mispredict_count is 0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Storage: circular buffer of {pc, pred_taken, pred_target}. Head and tail wrap from DEPTH-1 to 0. count is DEPTH_LOG2+1 bits.
- Push: if push=1 and (full=0, or a valid pop occurs in the same cycle), write the entry at tail and advance tail. A push while full with no pop is silently dropped and count is unchanged.
- Resolve validity: valid when resolve=1, empty=0 and head.pc == resolve_pc.
  - Otherwise order_error pulses the next cycle, with no pop and no blt_write.
- Valid resolve pops head. Next-cycle outputs:
  - blt_write = resolve_taken | head.pred_taken. Not-taken branches that were predicted not-taken are never written.
  - blt_write_key = resolve_pc, blt_write_val = resolve_target, blt_hit = resolve_taken.
  - Mispredict condition: (head.pred_taken != resolve_taken), or (both taken and head.pred_target != resolve_target).
  - On mispredict: mispredict=1, redirect_pc = resolve_taken ? resolve_target : resolve_pc + 1 (word-addressed, modulo 2^ADDR_WIDTH).
- Flush: on a mispredicting resolve, the queue empties at the same edge (head=tail=0, count=0). A push in that same cycle is discarded, because it is on the wrong path.
- Simultaneous push and correct resolve: both take effect and count is unchanged. This is legal even when full.
- Latency: resolve to blt_write/mispredict is exactly 1 cycle. Push to an entry resolvable is 1 cycle (the entry is visible at head the cycle after it is written into an empty queue).
- All pulse outputs (blt_write, mispredict, order_error) are 0 in any cycle not following a qualifying resolve.
- mispredict_count: +1 per mispredict, saturating at all-ones and never wrapping.

Test Plan:
- Reset, then push pc=0x0010 taken target=0x0040; next cycle resolve pc=0x0010 taken target=0x0040 -> blt_write=1, key=0x0010, val=0x0040, hit=1, mispredict=0, empty=1.
- Push pc=0x0020 predicted not-taken; resolve taken target=0x0080 -> mispredict=1, redirect_pc=0x0080, blt_hit=1, mispredict_count=1.
- Push pc=0x0030 predicted taken to 0x0050; resolve not-taken -> mispredict=1, redirect_pc=0x0031, blt_write=1, blt_hit=0. In the same cycle push pc=0x0031 -> dropped, empty=1.
- Push 8 branches -> full=1. 9th push ignored. Then push and correct-resolve in the same cycle -> count stays 8. Drain 8 correct resolves with wrap-around -> empty=1, entries returned in push order.
- Resolve while empty, and resolve with pc=0x0099 when head pc=0x0010 -> order_error pulse each time, no blt_write, count unchanged.
- Force mispredict_count to all-ones via 65535 mispredicts (or a shortened CNT_WIDTH=4 build, 15 mispredicts), then one more mispredict -> count holds 0xF. Assert reset mid-queue -> empty=1 and all outputs 0 asynchronously.
